multicycle_sequencer: RTL
=========================

// Module: multicycle_sequencer
// PURPOSE
//   Multi-cycle control FSM for KGP-RISC. Steps each instruction through FETCH/DECODE/EXEC/MEM/WB
//   and issues per-cycle datapath strobes. Handshakes with instruction and data memories that
//   have variable latency. Sits beside main_control, which still supplies alu_op/alu_source/write_reg.
// PARAMETERS
//   MEM_TIMEOUT  15  max wait cycles for imem_ready/dmem_ready before trapping (1..255)
//   COUNT_W      32  width of retired-instruction counter
// PORTS
//   clk          in   1        system clock, all state on rising edge
//   rst          in   1        synchronous, active-low reset
//   run          in   1        1 = execute instructions, 0 = stop at next instruction boundary
//   opcode       in   6        IR[31:26], stable from the cycle after ir_write
//   flag_zero    in   1        ALU zero flag, valid in EXEC
//   flag_carry   in   1        ALU carry flag, valid in EXEC
//   imem_ready   in   1        instruction word valid this cycle
//   dmem_ready   in   1        data access complete this cycle
//   imem_req     out  1        instruction fetch request
//   ir_write     out  1        load IR (1-cycle pulse)
//   pc_inc       out  1        PC <= PC+4 (1-cycle pulse, same cycle as ir_write)
//   pc_load      out  1        PC <= branch target (1-cycle pulse)
//   alu_en       out  1        ALU result/flag register enable
//   dmem_rd      out  1        data memory read request
//   dmem_wr      out  1        data memory write request
//   reg_write    out  1        register file write enable
//   wb_sel       out  2        00 ALU, 01 memory, 10 link (PC)
//   retire       out  1        1-cycle pulse when an instruction completes
//   instr_count  out  COUNT_W  retired-instruction count
//   busy         out  1        1 in any state other than IDLE/TRAP
//   trap         out  1        sticky error indication
//   trap_cause   out  2        00 none, 01 illegal opcode, 10 memory timeout
// BEHAVIOUR
//   Reset (rst==0 at clk edge, any state): state=IDLE. All outputs 0. instr_count=0. Wait counter=0.
//   States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. Outputs decoded from registered state and inputs.
//   IDLE: run=1 -> FETCH next cycle; else stay.
//   FETCH: imem_req=1 until imem_ready is sampled 1.
//     On that cycle: ir_write=1, pc_inc=1 -> DECODE.
//   DECODE: no strobes. Opcode in {000000..000110, 111100..111111} -> EXEC. Any other -> TRAP, cause 01.
//   EXEC: alu_en=1. Next state by opcode:
//     000000/000001/000010 (ALU reg/imm/shift) -> WB, wb_sel=00
//     000011 (lw) -> MEM read; 000100 (sw) -> MEM write
//     000101 (bz): pc_load=flag_zero; 000110 (br reg): pc_load=1; 111100 (b): pc_load=1
//     111101 (bl): pc_load=1 -> WB, wb_sel=10
//     111110 (bcy): pc_load=flag_carry; 111111 (bncy): pc_load=~flag_carry
//     Branches other than bl retire in EXEC.
//   MEM: dmem_rd (lw) or dmem_wr (sw) held high until dmem_ready is sampled 1.
//     lw -> WB, wb_sel=01. sw retires in MEM.
//   WB: reg_write=1, wb_sel per opcode, retire.
//   Retire: retire=1 in the completing cycle. instr_count increments on the next edge and wraps at 2^COUNT_W.
//     After retire: run=1 -> FETCH, run=0 -> IDLE. run is ignored mid-instruction.
//   Wait counter: cleared on entry to FETCH/MEM, increments each cycle ready=0.
//     Reaching MEM_TIMEOUT with ready=0 -> TRAP, cause 10, request dropped.
//     Ready=1 in the same cycle as the timeout wins: normal completion.
//   TRAP: all strobes 0, trap=1, trap_cause held. Exit only via reset. No retire for the faulting instruction.
//   Zero-wait latencies (ready=1 on first cycle): ALU/bl 4, lw 5, sw 4, other branches 3 cycles.
//   wb_sel holds its last value outside WB. Strobes are mutually consistent: never dmem_rd & dmem_wr.
// TESTING
//   Reset, run=1, opcode=000000, readys tied 1: FETCH,DECODE,EXEC,WB. reg_write in cycle 4. instr_count=1.
//   lw with dmem_ready low 3 cycles: dmem_rd high exactly 4 cycles, then WB with wb_sel=01. Total 8 cycles.
//   bcy with flag_carry=1: pc_load=1 in EXEC. bncy with flag_carry=1: pc_load=0. Each retires in 3 cycles.
//   opcode=001000: TRAP after DECODE, trap_cause=01, no retire. rst=0 returns to IDLE with count 0.
//   imem_ready held 0: TRAP after MEM_TIMEOUT=15 wait cycles, cause 10. Ready on cycle 15 completes normally.
//   Drop run during EXEC of bl: WB completes, then IDLE. Reset asserted mid-MEM: all outputs 0 next cycle.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for KGP-RISC: steps FETCH/DECODE/EXEC/MEM/WB,
// handshakes with variable-latency memories and traps on illegal opcodes or memory timeouts.
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int COUNT_W     = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [5:0]         opcode,
    input  logic               flag_zero,
    input  logic               flag_carry,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    output logic               imem_req,
    output logic               ir_write,
    output logic               pc_inc,
    output logic               pc_load,
    output logic               alu_en,
    output logic               dmem_rd,
    output logic               dmem_wr,
    output logic               reg_write,
    output logic [1:0]         wb_sel,
    output logic               retire,
    output logic [COUNT_W-1:0] instr_count,
    output logic               busy,
    output logic               trap,
    output logic [1:0]         trap_cause
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_e;

    localparam logic [5:0] OP_ALU_R = 6'b000000;
    localparam logic [5:0] OP_ALU_I = 6'b000001;
    localparam logic [5:0] OP_SHIFT = 6'b000010;
    localparam logic [5:0] OP_LW    = 6'b000011;
    localparam logic [5:0] OP_SW    = 6'b000100;
    localparam logic [5:0] OP_BZ    = 6'b000101;
    localparam logic [5:0] OP_BR    = 6'b000110;
    localparam logic [5:0] OP_B     = 6'b111100;
    localparam logic [5:0] OP_BL    = 6'b111101;
    localparam logic [5:0] OP_BCY   = 6'b111110;
    localparam logic [5:0] OP_BNCY  = 6'b111111;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_MEM  = 2'b01;
    localparam logic [1:0] WB_LINK = 2'b10;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // Last wait-counter value at which a missing ready is still tolerated.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [7:0]         wait_q, wait_d;
    logic [1:0]         wb_sel_q, wb_sel_d;
    logic [1:0]         cause_q, cause_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               opcode_legal;

    assign opcode_legal = (opcode <= OP_BR) || (opcode >= OP_B);

    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned; a missing default would infer a latch.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        wb_sel_d  = wb_sel_q;
        cause_d   = cause_q;
        count_d   = count_q;
        imem_req  = 1'b0;
        ir_write  = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        alu_en    = 1'b0;
        dmem_rd   = 1'b0;
        dmem_wr   = 1'b0;
        reg_write = 1'b0;
        retire    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    pc_inc   = 1'b1;
                    state_d  = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                if (opcode_legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            S_EXEC: begin
                alu_en = 1'b1;
                case (opcode)
                    OP_ALU_R, OP_ALU_I, OP_SHIFT: begin
                        state_d  = S_WB;
                        wb_sel_d = WB_ALU;
                    end
                    OP_LW, OP_SW: begin
                        state_d = S_MEM;
                        wait_d  = '0;
                    end
                    OP_BZ: begin
                        pc_load = flag_zero;
                        retire  = 1'b1;
                    end
                    OP_BR, OP_B: begin
                        pc_load = 1'b1;
                        retire  = 1'b1;
                    end
                    OP_BL: begin
                        pc_load  = 1'b1;
                        state_d  = S_WB;
                        wb_sel_d = WB_LINK;
                    end
                    OP_BCY: begin
                        pc_load = flag_carry;
                        retire  = 1'b1;
                    end
                    OP_BNCY: begin
                        pc_load = ~flag_carry;
                        retire  = 1'b1;
                    end
                    default: begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEM: begin
                dmem_rd = (opcode == OP_LW);
                dmem_wr = (opcode != OP_LW);
                if (dmem_ready) begin
                    if (opcode == OP_LW) begin
                        state_d  = S_WB;
                        wb_sel_d = WB_MEM;
                    end else begin
                        retire = 1'b1;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_TRAP: ;
            default: state_d = S_IDLE;
        endcase

        // Instruction boundary: run is only consulted here and in IDLE.
        if (retire) begin
            count_d = count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
            wait_d  = '0;
            state_d = run ? S_FETCH : S_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            wait_q   <= '0;
            wb_sel_q <= WB_ALU;
            cause_q  <= 2'b00;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            wb_sel_q <= wb_sel_d;
            cause_q  <= cause_d;
            count_q  <= count_d;
        end
    end

    assign wb_sel      = wb_sel_q;
    assign instr_count = count_q;
    assign trap        = (state_q == S_TRAP);
    assign trap_cause  = cause_q;
    assign busy        = (state_q != S_IDLE) && (state_q != S_TRAP);

endmodule
